data_bus_responder: RTL and testbench

//  Responder side of the CPU data-memory interface (data_addr/ren/rd/wen/wr/wstrb).

---
 rtl/data_bus_responder_pkg.sv | 41 ++++
 rtl/data_bus_responder_tx_fifo.sv | 56 +++++
 rtl/data_bus_responder.sv | 159 +++++++++++++++
 tb/tb_data_bus_responder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_responder_pkg.sv
// Purpose: shared memory map, register offsets and helpers for the data-bus responder.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package data_bus_responder_pkg;

  // MMIO window: 64 bytes starting at the base, decoded on word offsets
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_WIN_MASK     = 32'h0000_003F;

  localparam logic [5:0] OFF_LED    = 6'h00;
  localparam logic [5:0] OFF_CYCLES = 6'h04;
  localparam logic [5:0] OFF_TCMP   = 6'h08;
  localparam logic [5:0] OFF_TSTAT  = 6'h0C;
  localparam logic [5:0] OFF_TXDATA = 6'h10;
  localparam logic [5:0] OFF_TXSTAT = 6'h14;

  // TXSTAT bit positions
  localparam int TXS_FULL    = 0;
  localparam int TXS_EMPTY   = 1;
  localparam int TXS_OVF     = 2;
  localparam int TXS_CNT_LSB = 3;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_RAM,
    REGION_MMIO
  } region_e;

  // Merge new_w into old_w on the bytes whose strobe is set
  function automatic logic [31:0] apply_strb(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_bus_responder_tx_fifo.sv
// Purpose: generic synchronous FIFO with occupancy count, used for the TX byte stream.
// Latency: a pushed entry is visible at head_o one cycle after the push edge (no bypass).
// Backpressure: push into a full FIFO is ignored unless a pop happens in the same cycle.
module data_bus_responder_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  // Head reads zero while empty so the stream output is clean after reset
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/data_bus_responder.sv
// Purpose: CPU data-bus responder serving word RAM plus LED/cycle/timer/TX-FIFO MMIO registers.
// Latency: reads are combinational in the same cycle; writes commit at the next rising edge.
// Backpressure: never stalls the CPU; TX bytes drain on tx_valid/tx_ready, pushes into a full FIFO are dropped.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4,
  // Reset value of the cycle counter; left at zero except to exercise rollover
  parameter logic [31:0] CYCLES_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic        data_ren,
  output logic [31:0] data_rd,
  input  logic        data_wen,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_wstrb,
  output logic [15:0] led,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_err
);
  localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  logic [31:0] ram_q [RAM_WORDS];
  logic [15:0] led_q, led_d;
  logic [31:0] cycles_q, cycles_d, tcmp_q, tcmp_d;
  logic        irq_q, irq_d, ovf_q, ovf_d, err_q, err_d;

  region_e                   region;
  logic [5:0]                mmio_off;
  logic [AW-1:0]             ram_idx;
  logic                      mmio_wr, tx_push, tx_pop, tx_drop;
  logic [7:0]                fifo_head;
  logic                      fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic [2:0]                cnt_sat;
  logic [31:0]               rd_val;

  assign mmio_off = {data_addr[5:2], 2'b00};
  assign ram_idx  = data_addr[AW+1:2];

  // Address decode; window offsets past TXSTAT are treated as unmapped
  always_comb begin
    region = REGION_NONE;
    if ({1'b0, data_addr} < RAM_BYTES) begin
      region = REGION_RAM;
    end else if (((data_addr & ~MMIO_WIN_MASK) == MMIO_BASE) && (mmio_off <= OFF_TXSTAT)) begin
      region = REGION_MMIO;
    end
  end

  assign mmio_wr = data_wen && (region == REGION_MMIO);
  assign tx_push = mmio_wr && (mmio_off == OFF_TXDATA) && data_wstrb[0];
  assign tx_pop  = !fifo_empty && tx_ready;
  assign tx_drop = tx_push && fifo_full && !tx_pop;
  assign cnt_sat = (32'(fifo_cnt) > 32'd7) ? 3'd7 : 3'(fifo_cnt);

  data_bus_responder_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (tx_push),
    .push_dat_i (data_wr[7:0]),
    .pop_i      (tx_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  // Next-state for MMIO registers; timer set and overflow set take priority over W1C
  always_comb begin
    led_d    = led_q;
    cycles_d = cycles_q + 32'd1;
    tcmp_d   = tcmp_q;
    irq_d    = irq_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    if (mmio_wr && (mmio_off == OFF_LED)) begin
      if (data_wstrb[0]) led_d[7:0]  = data_wr[7:0];
      if (data_wstrb[1]) led_d[15:8] = data_wr[15:8];
    end
    if (mmio_wr && (mmio_off == OFF_TCMP)) tcmp_d = apply_strb(tcmp_q, data_wr, data_wstrb);
    if (mmio_wr && (mmio_off == OFF_TSTAT) && data_wstrb[0] && data_wr[0]) irq_d = 1'b0;
    if ((cycles_q == tcmp_q) && (tcmp_q != '0)) irq_d = 1'b1;
    if (mmio_wr && (mmio_off == OFF_TXSTAT) && data_wstrb[0] && data_wr[TXS_OVF]) ovf_d = 1'b0;
    if (tx_drop) ovf_d = 1'b1;
    if ((data_ren || data_wen) && (region == REGION_NONE)) err_d = 1'b1;
  end

  // MMIO register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q    <= '0;
      cycles_q <= CYCLES_RST;
      tcmp_q   <= '0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      cycles_q <= cycles_d;
      tcmp_q   <= tcmp_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // RAM keeps its contents through reset, so it has no reset branch
  always_ff @(posedge clk) begin
    if (data_wen && (region == REGION_RAM)) begin
      ram_q[ram_idx] <= apply_strb(ram_q[ram_idx], data_wr, data_wstrb);
    end
  end

  // Read mux from pre-edge state; write-only and unmapped locations read zero
  always_comb begin
    rd_val = '0;
    if (data_ren) begin
      case (region)
        REGION_RAM: rd_val = ram_q[ram_idx];
        REGION_MMIO: begin
          case (mmio_off)
            OFF_LED:    rd_val = {16'h0, led_q};
            OFF_CYCLES: rd_val = cycles_q;
            OFF_TCMP:   rd_val = tcmp_q;
            OFF_TSTAT:  rd_val[0] = irq_q;
            OFF_TXSTAT: begin
              rd_val[TXS_FULL]             = fifo_full;
              rd_val[TXS_EMPTY]            = fifo_empty;
              rd_val[TXS_OVF]              = ovf_q;
              rd_val[TXS_CNT_LSB +: 3]     = cnt_sat;
            end
            default: rd_val = '0;
          endcase
        end
        default: rd_val = '0;
      endcase
    end
  end

  assign data_rd  = rd_val;
  assign led      = led_q;
  assign irq      = irq_q;
  assign bus_err  = err_q;
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_head;

endmodule

// File: tb/tb_data_bus_responder.sv
// Purpose: self-checking bench for data_bus_responder: vector table, directed corner cases, random vs model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled mid-cycle.
// Backpressure: tx_ready driven directly by the bench (held low, high, or random).
module tb_data_bus_responder;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk;
  logic        rst, rst_w;
  logic [31:0] data_addr, data_rd, data_wr;
  logic        data_ren, data_wen, tx_ready;
  logic [3:0]  data_wstrb;
  logic [15:0] led;
  logic        irq, tx_valid, bus_err;
  logic [7:0]  tx_data;
  // second instance, only used to watch the cycle counter roll over
  logic [31:0] w_rd;
  logic [15:0] w_led;
  logic        w_irq, w_txv, w_err;
  logic [7:0]  w_txd;

  int errors = 0;
  int checks = 0;

  data_bus_responder dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .data_ren(data_ren), .data_rd(data_rd),
    .data_wen(data_wen), .data_wr(data_wr), .data_wstrb(data_wstrb), .led(led), .irq(irq),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_err(bus_err)
  );

  data_bus_responder #(.CYCLES_RST(32'hFFFF_FFFD)) dut_wrap (
    .clk(clk), .rst(rst_w), .data_addr(MB + 32'h4), .data_ren(1'b1), .data_rd(w_rd),
    .data_wen(1'b0), .data_wr(32'h0), .data_wstrb(4'h0), .led(w_led), .irq(w_irq),
    .tx_data(w_txd), .tx_valid(w_txv), .tx_ready(1'b0), .bus_err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    data_ren = 1'b0; data_wen = 1'b0; data_addr = '0; data_wr = '0; data_wstrb = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    data_addr = a; data_wr = d; data_wstrb = s; data_wen = 1'b1; data_ren = 1'b0;
    step();
    idle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    data_addr = a; data_ren = 1'b1; data_wen = 1'b0;
    #3 d = data_rd;
    step();
    idle();
  endtask

  task automatic do_reset();
    idle(); tx_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] txstat(input int cnt, input bit ovf);
    logic [31:0] r;
    r = '0;
    r[5:3] = 3'((cnt > 7) ? 7 : cnt);
    r[2] = ovf;
    r[1] = (cnt == 0);
    r[0] = (cnt == 4);
    return r;
  endfunction

  vec_t        vecs[$];
  logic [31:0] v, c, exp_cyc;
  bit          irq_m;
  logic [7:0]  drain_exp [4];
  // random-phase model state
  logic [31:0] mem_m [8];
  logic [7:0]  q_m [$];
  logic [15:0] led_m;
  bit          ovf_m;

  initial begin
    rst = 1'b1; rst_w = 1'b1; tx_ready = 1'b0; idle();
    step(); step();

    // ---- reset values (reset still asserted) ----
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    data_addr = MB + 32'h4; data_ren = 1'b1; #1;
    chk("rst_cycles", data_rd, 32'h0);
    data_addr = MB + 32'h14; #1;
    chk("rst_txstat", data_rd, 32'h2);
    idle();

    // ---- timer: TCMP=20, irq from the edge where cycles==20 ----
    do_reset();
    wr(MB + 32'h8, 32'd20, 4'hF);
    irq_m = 1'b0; exp_cyc = 32'd1;
    for (int i = 0; i < 30; i++) begin
      data_addr = MB + 32'h4; data_ren = 1'b1;
      #3 c = data_rd;
      chk("cycles_seq", c, exp_cyc);
      chk("irq_timer", 32'(irq), 32'(irq_m));
      step();
      if (c == 32'd20) irq_m = 1'b1;
      exp_cyc = exp_cyc + 32'd1;
    end
    idle();
    chk("irq_set", 32'(irq), 32'h1);
    wr(MB + 32'hC, 32'h1, 4'h1);
    chk("irq_w1c", 32'(irq), 32'h0);
    rd(MB + 32'hC, v);
    chk("tstat_cleared", v, 32'h0);
    // CYCLES is read-only
    rd(MB + 32'h4, c);
    wr(MB + 32'h4, 32'h0, 4'hF);
    rd(MB + 32'h4, v);
    chk("cycles_ro", v, c + 32'd2);
    // a TCMP write matching the current count only compares from the next cycle
    rd(MB + 32'h4, c);
    wr(MB + 32'h8, c + 32'd1, 4'hF);
    chk("tcmp_next_cycle", 32'(irq), 32'h0);
    step();
    chk("tcmp_next_cycle2", 32'(irq), 32'h0);
    // set and W1C in the same cycle: set wins
    rd(MB + 32'h4, c);
    wr(MB + 32'h8, c + 32'd3, 4'hF);
    step();
    wr(MB + 32'hC, 32'h1, 4'h1);
    chk("irq_set_wins", 32'(irq), 32'h1);
    wr(MB + 32'hC, 32'h1, 4'h1);
    chk("irq_clear_after", 32'(irq), 32'h0);
    wr(MB + 32'h8, 32'h0, 4'hF);

    // ---- cycle counter rollover on the second instance ----
    rst_w = 1'b1; step(); rst_w = 1'b0;
    exp_cyc = 32'hFFFF_FFFD;
    for (int i = 0; i < 6; i++) begin
      #3 chk("cycles_wrap", w_rd, exp_cyc);
      step();
      exp_cyc = exp_cyc + 32'd1;
    end

    // ---- vector table ----
    do_reset();
    vecs.push_back('{1'b0, 1'b1, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h00BB_00DD, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 32'h00BB_00DD, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h13, 32'h0, 4'h0, 32'h1234_5678, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b0, 1'b1, MB, 32'h0000_1234, 4'h2, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, MB, 32'h0, 4'h0, 32'h0000_1200, 1'b0});
    vecs.push_back('{1'b0, 1'b1, MB, 32'hFFFF_5678, 4'h3, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, MB, 32'h0, 4'h0, 32'h0000_5678, 1'b0});
    vecs.push_back('{1'b0, 1'b1, MB + 32'h8, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, MB + 32'h8, 32'h1100_0000, 4'h8, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, MB + 32'h8, 32'h0, 4'h0, 32'h11AD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, MB + 32'h8, 32'h0, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, MB + 32'h10, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, MB + 32'h14, 32'h0, 4'h0, 32'h2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, MB + 32'hC, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0, 1'b1});
    foreach (vecs[i]) begin
      data_ren = vecs[i].ren; data_wen = vecs[i].wen; data_addr = vecs[i].addr;
      data_wr = vecs[i].wdat; data_wstrb = vecs[i].strb;
      #3 chk($sformatf("vec%0d_rd", i), data_rd, vecs[i].exp_rd);
      step();
      chk($sformatf("vec%0d_err", i), 32'(bus_err), 32'(vecs[i].exp_err));
    end
    idle();
    chk("led_out", 32'(led), 32'h5678);

    // ---- RAM survives reset; bus_err cleared then set by unmapped MMIO write ----
    do_reset();
    chk("rst2_bus_err", 32'(bus_err), 32'h0);
    chk("rst2_led", 32'(led), 32'h0);
    rd(32'h10, v);
    chk("ram_survive_10", v, 32'h1234_5678);
    rd(32'hFFC, v);
    chk("ram_survive_ffc", v, 32'hCAFE_F00D);
    wr(MB + 32'h20, 32'hFFFF_FFFF, 4'hF);
    chk("err_mmio_gap", 32'(bus_err), 32'h1);
    step(); step(); step();
    chk("err_sticky", 32'(bus_err), 32'h1);
    chk("led_untouched", 32'(led), 32'h0);

    // ---- FIFO: fill with tx_ready low, overflow on fifth push ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      data_addr = MB + 32'h10; data_wr = 32'h41 + 32'(i); data_wstrb = 4'h1; data_wen = 1'b1;
      #3;
      if (i == 0) chk("no_bypass", 32'(tx_valid), 32'h0);
      else begin
        chk("tx_valid_up", 32'(tx_valid), 32'h1);
        chk("tx_hold", 32'(tx_data), 32'h41);
      end
      step();
    end
    idle();
    rd(MB + 32'h14, v);
    chk("txstat_full_ovf", v, 32'h25);
    wr(MB + 32'h14, 32'h4, 4'h1);
    rd(MB + 32'h14, v);
    chk("txstat_ovf_w1c", v, 32'h21);
    // push while full with a pop in the same cycle
    data_addr = MB + 32'h10; data_wr = 32'h55; data_wstrb = 4'h1; data_wen = 1'b1; tx_ready = 1'b1;
    #3 chk("pop_head", 32'(tx_data), 32'h41);
    step(); idle(); tx_ready = 1'b0;
    rd(MB + 32'h14, v);
    chk("txstat_push_pop_full", v, 32'h21);
    drain_exp[0] = 8'h42; drain_exp[1] = 8'h43; drain_exp[2] = 8'h44; drain_exp[3] = 8'h55;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("drain_valid", 32'(tx_valid), 32'h1);
      chk("drain_data", 32'(tx_data), 32'(drain_exp[i]));
      step();
    end
    #3 chk("drained_valid", 32'(tx_valid), 32'h0);
    step();
    tx_ready = 1'b0;
    rd(MB + 32'h14, v);
    chk("txstat_empty", v, 32'h2);

    // ---- reset mid-operation discards queued bytes at once ----
    wr(MB + 32'h10, 32'h61, 4'h1);
    wr(MB + 32'h10, 32'h62, 4'h1);
    wr(MB + 32'h10, 32'h63, 4'h1);
    chk("queued_valid", 32'(tx_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(tx_valid), 32'h0);
    chk("async_rst_data", 32'(tx_data), 32'h0);
    data_addr = MB + 32'h14; data_ren = 1'b1; #1;
    chk("async_rst_txstat", data_rd, 32'h2);
    idle();
    step();
    rst = 1'b0;

    // ---- random traffic against a behavioural model ----
    do_reset();
    led_m = '0; ovf_m = 1'b0; q_m.delete();
    for (int i = 0; i < 8; i++) begin
      mem_m[i] = $urandom;
      wr(32'h100 + 32'(4*i), mem_m[i], 4'hF);
    end
    for (int n = 0; n < 400; n++) begin
      int          op, idx;
      logic [31:0] a, wd, exp_rd;
      logic [3:0]  st;
      bit          do_rd, push, pop;
      op = $urandom_range(0, 5); idx = $urandom_range(0, 7);
      wd = $urandom; st = 4'($urandom_range(0, 15));
      a = 32'h100 + 32'(4*idx);
      tx_ready = 1'($urandom_range(0, 1));
      idle(); do_rd = 1'b0; push = 1'b0; exp_rd = '0;
      case (op)
        0: begin data_addr = a; data_wen = 1'b1; data_wr = wd; data_wstrb = st; end
        1: begin data_addr = a; data_ren = 1'b1; do_rd = 1'b1; exp_rd = mem_m[idx]; end
        2: begin
          data_addr = a; data_ren = 1'b1; data_wen = 1'b1; data_wr = wd; data_wstrb = st;
          do_rd = 1'b1; exp_rd = mem_m[idx];
        end
        3: begin
          data_addr = MB + 32'h10; data_wen = 1'b1; data_wr = wd; data_wstrb = st;
          push = st[0];
        end
        4: begin data_addr = MB; data_wen = 1'b1; data_wr = wd; data_wstrb = st; end
        default: begin
          data_ren = 1'b1; do_rd = 1'b1;
          if (idx[0]) begin data_addr = MB; exp_rd = {16'h0, led_m}; end
          else begin data_addr = MB + 32'h14; exp_rd = txstat(q_m.size(), ovf_m); end
        end
      endcase
      #3;
      chk("rnd_tx_valid", 32'(tx_valid), 32'(q_m.size() != 0));
      if (q_m.size() != 0) chk("rnd_tx_data", 32'(tx_data), 32'(q_m[0]));
      if (do_rd) chk("rnd_rd", data_rd, exp_rd);
      step();
      pop = (q_m.size() != 0) && tx_ready;
      if (pop) void'(q_m.pop_front());
      if (push) begin
        if (q_m.size() < 4) q_m.push_back(wd[7:0]);
        else ovf_m = 1'b1;
      end
      if (op == 0 || op == 2) begin
        for (int b = 0; b < 4; b++) if (st[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
      end
      if (op == 4) begin
        if (st[0]) led_m[7:0] = wd[7:0];
        if (st[1]) led_m[15:8] = wd[15:8];
      end
    end
    idle();
    chk("rnd_led_final", 32'(led), 32'(led_m));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
